// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: requests instructions from a variable-latency
// memory and presents PC/instruction pairs (or bubbles) to the IF/ID register.
// The PC advances only when the presented instruction is accepted downstream.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branchTaken,
  input  logic [31:0] branchAddr,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemRdata,
  output logic [31:0] pcOut,
  output logic [31:0] instOut,
  output logic        instValid
);

  localparam int unsigned XLEN = 32;

  // REQ: request outstanding to pc; DROP: stale request pending after a
  // redirect; HOLD: fetched instruction parked while downstream is frozen.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_DROP = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   pc_next;
  logic [XLEN-1:0]   req_addr;
  logic [XLEN-1:0]   req_addr_next;
  logic [XLEN-1:0]   hold_inst;
  logic [XLEN-1:0]   hold_inst_next;
  logic [XLEN-1:0]   pc_inc;

  // Sequential PC, wraps modulo 2^32.
  assign pc_inc = pc + XLEN'(PC_STEP);

  // State and fetch registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      req_addr  <= RESET_PC;
      hold_inst <= '0;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      req_addr  <= req_addr_next;
      hold_inst <= hold_inst_next;
    end
  end

  // Next-state and register updates; redirect beats freeze beats normal flow.
  always_comb begin
    state_next     = state;
    pc_next        = pc;
    req_addr_next  = req_addr;
    hold_inst_next = hold_inst;
    case (state)
      S_REQ: begin
        if (imemAck) begin
          if (branchTaken) begin
            pc_next       = branchAddr;
            req_addr_next = branchAddr;
          end else if (freeze) begin
            hold_inst_next = imemRdata;
            state_next     = S_HOLD;
          end else begin
            pc_next       = pc_inc;
            req_addr_next = pc_inc;
          end
        end else if (branchTaken) begin
          // Request must stay up on its old address until the memory answers.
          pc_next    = branchAddr;
          state_next = S_DROP;
        end
      end
      S_DROP: begin
        if (branchTaken) begin
          pc_next = branchAddr;
        end
        if (imemAck) begin
          req_addr_next = branchTaken ? branchAddr : pc;
          state_next    = S_REQ;
        end
      end
      S_HOLD: begin
        if (branchTaken) begin
          pc_next       = branchAddr;
          req_addr_next = branchAddr;
          state_next    = S_REQ;
        end else if (!freeze) begin
          pc_next       = pc_inc;
          req_addr_next = pc_inc;
          state_next    = S_REQ;
        end
      end
      default: begin
        state_next = S_REQ;
      end
    endcase
  end

  // Outputs: combinational from state, registers and the memory response.
  always_comb begin
    imemReq   = 1'b0;
    imemAddr  = '0;
    instValid = 1'b0;
    instOut   = '0;
    pcOut     = '0;
    if (rst) begin
      case (state)
        S_REQ: begin
          imemReq  = 1'b1;
          imemAddr = req_addr;
          if (imemAck && !branchTaken) begin
            instValid = 1'b1;
            instOut   = imemRdata;
            pcOut     = pc_inc;
          end
        end
        S_DROP: begin
          imemReq  = 1'b1;
          imemAddr = req_addr;
        end
        S_HOLD: begin
          imemAddr  = req_addr;
          instValid = 1'b1;
          instOut   = hold_inst;
          pcOut     = pc_inc;
        end
        default: begin
          imemReq = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed testbench for if_fetch_unit: the bench plays the instruction memory
// by driving imemAck/imemRdata cycle by cycle.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branchTaken;
  logic [31:0] branchAddr;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemRdata;
  logic [31:0] pcOut;
  logic [31:0] instOut;
  logic        instValid;

  int tests;
  int failed;

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branchTaken(branchTaken),
    .branchAddr(branchAddr), .imemReq(imemReq), .imemAddr(imemAddr),
    .imemAck(imemAck), .imemRdata(imemRdata), .pcOut(pcOut),
    .instOut(instOut), .instValid(instValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for one edge, release it; first REQ cycle follows.
  task automatic do_reset();
    rst = 1'b0; freeze = 1'b0; branchTaken = 1'b0; branchAddr = '0;
    imemAck = 1'b0; imemRdata = '0;
    next_cycle();
    rst = 1'b1;
  endtask

  // Accept n instructions from a zero-wait memory.
  task automatic run_zero_wait(input int n);
    for (int i = 0; i < n; i++) begin
      imemAck = 1'b1; imemRdata = 32'hA000_0000 + 32'(i);
      next_cycle();
    end
    imemAck = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; freeze = 1'b0; branchTaken = 1'b0; branchAddr = '0;
    imemAck = 1'b1; imemRdata = 32'hFFFF_FFFF;
    @(negedge clk);
    tests++; if (imemReq !== 1'b0) begin $display("FAIL reset_req got %b exp 0", imemReq); failed++; end
    tests++; if (instValid !== 1'b0) begin $display("FAIL reset_valid got %b exp 0", instValid); failed++; end
    tests++; if (pcOut !== 32'h0) begin $display("FAIL reset_pcout got %h exp 0", pcOut); failed++; end
    tests++; if (instOut !== 32'h0) begin $display("FAIL reset_inst got %h exp 0", instOut); failed++; end
    next_cycle();
    rst = 1'b1; imemAck = 1'b0;
    @(negedge clk);
    tests++; if (imemReq !== 1'b1) begin $display("FAIL first_req got %b exp 1", imemReq); failed++; end
    tests++; if (imemAddr !== 32'h0) begin $display("FAIL first_addr got %h exp 0", imemAddr); failed++; end
  endtask

  task automatic test_zero_wait();
    logic [31:0] data;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      data = 32'h1111_0000 + 32'(i);
      imemAck = 1'b1; imemRdata = data;
      @(negedge clk);
      tests++; if (instValid !== 1'b1) begin $display("FAIL zw_valid[%0d] got %b exp 1", i, instValid); failed++; end
      tests++; if (imemAddr !== 32'(4 * i)) begin $display("FAIL zw_addr[%0d] got %h exp %h", i, imemAddr, 32'(4 * i)); failed++; end
      tests++; if (pcOut !== 32'(4 * i + 4)) begin $display("FAIL zw_pcout[%0d] got %h exp %h", i, pcOut, 32'(4 * i + 4)); failed++; end
      tests++; if (instOut !== data) begin $display("FAIL zw_inst[%0d] got %h exp %h", i, instOut, data); failed++; end
      next_cycle();
    end
    imemAck = 1'b0;
  endtask

  task automatic test_latency();
    do_reset();
    imemAck = 1'b0;
    @(negedge clk);
    tests++; if (imemAddr !== 32'h0) begin $display("FAIL lat_addr1 got %h exp 0", imemAddr); failed++; end
    tests++; if (instValid !== 1'b0) begin $display("FAIL lat_valid1 got %b exp 0", instValid); failed++; end
    next_cycle();
    imemAck = 1'b1; imemRdata = 32'h0BAD_F00D;
    @(negedge clk);
    tests++; if (imemAddr !== 32'h0) begin $display("FAIL lat_addr2 got %h exp 0", imemAddr); failed++; end
    tests++; if (instValid !== 1'b1) begin $display("FAIL lat_valid2 got %b exp 1", instValid); failed++; end
    tests++; if (pcOut !== 32'h4) begin $display("FAIL lat_pcout got %h exp 4", pcOut); failed++; end
    next_cycle();
    imemAck = 1'b0;
    @(negedge clk);
    tests++; if (imemAddr !== 32'h4) begin $display("FAIL lat_next_addr got %h exp 4", imemAddr); failed++; end
    next_cycle();
  endtask

  task automatic test_freeze_hold();
    do_reset();
    run_zero_wait(2);
    imemAck = 1'b1; imemRdata = 32'h1234_5678; freeze = 1'b1;
    @(negedge clk);
    tests++; if (imemAddr !== 32'h8) begin $display("FAIL frz_addr got %h exp 8", imemAddr); failed++; end
    tests++; if (instValid !== 1'b1 || instOut !== 32'h1234_5678) begin $display("FAIL frz_present got %b/%h exp 1/12345678", instValid, instOut); failed++; end
    next_cycle();
    imemAck = 1'b0; imemRdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++; if (imemReq !== 1'b0) begin $display("FAIL hold_req[%0d] got %b exp 0", i, imemReq); failed++; end
      tests++; if (instOut !== 32'h1234_5678) begin $display("FAIL hold_inst[%0d] got %h exp 12345678", i, instOut); failed++; end
      tests++; if (pcOut !== 32'hC) begin $display("FAIL hold_pcout[%0d] got %h exp c", i, pcOut); failed++; end
      next_cycle();
    end
    freeze = 1'b0;
    @(negedge clk);
    tests++; if (instValid !== 1'b1 || instOut !== 32'h1234_5678) begin $display("FAIL unfrz_present got %b/%h exp 1/12345678", instValid, instOut); failed++; end
    next_cycle();
    @(negedge clk);
    tests++; if (imemAddr !== 32'hC || imemReq !== 1'b1) begin $display("FAIL unfrz_next got %h/%b exp c/1", imemAddr, imemReq); failed++; end
    tests++; if (instValid !== 1'b0) begin $display("FAIL unfrz_dup got %b exp 0", instValid); failed++; end
    next_cycle();
  endtask

  task automatic test_branch_drop();
    do_reset();
    run_zero_wait(4);
    imemAck = 1'b0; branchTaken = 1'b1; branchAddr = 32'h100;
    @(negedge clk);
    tests++; if (imemAddr !== 32'h10 || instValid !== 1'b0) begin $display("FAIL br_req got %h/%b exp 10/0", imemAddr, instValid); failed++; end
    next_cycle();
    branchTaken = 1'b0; branchAddr = '0;
    @(negedge clk);
    tests++; if (imemReq !== 1'b1 || imemAddr !== 32'h10) begin $display("FAIL drop_hold got %b/%h exp 1/10", imemReq, imemAddr); failed++; end
    tests++; if (instValid !== 1'b0) begin $display("FAIL drop_valid1 got %b exp 0", instValid); failed++; end
    next_cycle();
    imemAck = 1'b1; imemRdata = 32'hDEAD_DEAD;
    @(negedge clk);
    tests++; if (instValid !== 1'b0 || pcOut !== 32'h0) begin $display("FAIL drop_discard got %b/%h exp 0/0", instValid, pcOut); failed++; end
    tests++; if (imemAddr !== 32'h10) begin $display("FAIL drop_addr got %h exp 10", imemAddr); failed++; end
    next_cycle();
    imemAck = 1'b0;
    @(negedge clk);
    tests++; if (imemAddr !== 32'h100 || imemReq !== 1'b1) begin $display("FAIL drop_next got %h/%b exp 100/1", imemAddr, imemReq); failed++; end
    next_cycle();
  endtask

  task automatic test_branch_hold();
    do_reset();
    imemAck = 1'b1; imemRdata = 32'hAAAA_5555; freeze = 1'b1;
    next_cycle();
    imemAck = 1'b0; branchTaken = 1'b1; branchAddr = 32'h200;
    @(negedge clk);
    tests++; if (imemReq !== 1'b0) begin $display("FAIL bh_req got %b exp 0", imemReq); failed++; end
    next_cycle();
    branchTaken = 1'b0; freeze = 1'b0;
    @(negedge clk);
    tests++; if (imemAddr !== 32'h200 || instValid !== 1'b0) begin $display("FAIL bh_next got %h/%b exp 200/0", imemAddr, instValid); failed++; end
    imemAck = 1'b1; imemRdata = 32'hBBBB_0000; branchTaken = 1'b1; branchAddr = 32'h300;
    #1;
    tests++; if (instValid !== 1'b0 || pcOut !== 32'h0) begin $display("FAIL back_discard got %b/%h exp 0/0", instValid, pcOut); failed++; end
    next_cycle();
    imemAck = 1'b0; branchTaken = 1'b0;
    @(negedge clk);
    tests++; if (imemAddr !== 32'h300) begin $display("FAIL back_next got %h exp 300", imemAddr); failed++; end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    run_zero_wait(8);
    imemAck = 1'b0;
    @(negedge clk);
    tests++; if (imemAddr !== 32'h20 || imemReq !== 1'b1) begin $display("FAIL rm_wait got %h/%b exp 20/1", imemAddr, imemReq); failed++; end
    next_cycle();
    rst = 1'b0;
    #1;
    tests++; if (imemReq !== 1'b0 || imemAddr !== 32'h0 || instValid !== 1'b0) begin $display("FAIL rm_zero got %b/%h/%b exp 0/0/0", imemReq, imemAddr, instValid); failed++; end
    imemAck = 1'b1; imemRdata = 32'hCAFE_CAFE;
    #1;
    tests++; if (instValid !== 1'b0 || instOut !== 32'h0) begin $display("FAIL rm_ack_ignored got %b/%h exp 0/0", instValid, instOut); failed++; end
    next_cycle();
    rst = 1'b1; imemRdata = 32'h5555_0000;
    @(negedge clk);
    tests++; if (imemAddr !== 32'h0 || pcOut !== 32'h4) begin $display("FAIL rm_restart got %h/%h exp 0/4", imemAddr, pcOut); failed++; end
    next_cycle();
    imemAck = 1'b0;
    @(negedge clk);
    tests++; if (imemAddr !== 32'h4) begin $display("FAIL rm_seq got %h exp 4", imemAddr); failed++; end
    next_cycle();
  endtask

  task automatic test_wrap();
    do_reset();
    imemAck = 1'b1; branchTaken = 1'b1; branchAddr = 32'hFFFF_FFFC;
    next_cycle();
    branchTaken = 1'b0; imemRdata = 32'h7777_7777;
    @(negedge clk);
    tests++; if (imemAddr !== 32'hFFFF_FFFC || instValid !== 1'b1) begin $display("FAIL wrap_req got %h/%b exp fffffffc/1", imemAddr, instValid); failed++; end
    tests++; if (pcOut !== 32'h0) begin $display("FAIL wrap_pcout got %h exp 0", pcOut); failed++; end
    next_cycle();
    imemAck = 1'b0;
    @(negedge clk);
    tests++; if (imemAddr !== 32'h0) begin $display("FAIL wrap_next got %h exp 0", imemAddr); failed++; end
    next_cycle();
  endtask

  initial begin
    tests = 0;
    failed = 0;
    test_reset();
    test_zero_wait();
    test_latency();
    test_freeze_hold();
    test_branch_drop();
    test_branch_hold();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage that produces the PC/instruction pair consumed by the IF/ID pipeline register.
- Issues requests to a variable-latency instruction memory and advances the PC only when an instruction is actually accepted downstream.
- Holds a fetched instruction while the pipeline is frozen; on a branch redirect, drops any stale in-flight response.
- Drives a bubble indication (instValid=0) so the downstream register can load a NOP.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- freeze  input  1  downstream stall; the instruction presented this cycle is not accepted.
- branchTaken  input  1  redirect request from a later stage.
- branchAddr  input  32  redirect target PC.
- imemReq  output  1  memory request; level, held until imemAck.
- imemAddr  output  32  request address; stable while imemReq=1.
- imemAck  input  1  response valid; may assert in the same cycle as imemReq.
- imemRdata  input  32  instruction word, valid when imemAck=1.
- pcOut  output  32  PC of the presented instruction + PC_STEP.
- instOut  output  32  presented instruction.
- instValid  output  1  pcOut/instOut hold a real instruction; 0 = bubble.

Behaviour:
- Registers: pc (next instruction PC), reqAddr (outstanding address; drives imemAddr), holdInst, and state.
- Reset (rst=0, asynchronous): pc=reqAddr=RESET_PC, holdInst=0, state=REQ. While in reset: imemReq=0, instValid=0, pcOut=0, instOut=0.
- First request is issued in the first cycle after reset deasserts.
- Accept condition: instValid=1 & freeze=0 & branchTaken=0.
- Redirect priority: branchTaken > freeze > normal flow, in every state.
- State REQ: imemReq=1, imemAddr=reqAddr (equals pc).
  - imemAck & branchTaken: discard rdata; instValid=0; pc=reqAddr=branchAddr; stay REQ.
  - imemAck & freeze: instValid=1, instOut=imemRdata; capture holdInst=imemRdata; go HOLD.
  - imemAck, no freeze: accept; pc=reqAddr=pc+PC_STEP; stay REQ. This gives back-to-back fetches at 1 instr/cycle with a zero-wait memory.
  - No ack & branchTaken: pc=branchAddr; reqAddr unchanged; go DROP.
  - No ack otherwise: instValid=0; stay REQ.
- State DROP: imemReq=1, imemAddr=reqAddr (stale address); instValid=0 always.
  - branchTaken: pc=branchAddr (latest redirect wins).
  - imemAck: discard rdata; reqAddr=pc (updated value if a branch occurs in the same cycle); go REQ.
- State HOLD: imemReq=0; instValid=1, instOut=holdInst.
  - branchTaken: discard holdInst; pc=reqAddr=branchAddr; go REQ.
  - freeze=0: accept; pc=reqAddr=pc+PC_STEP; go REQ.
  - Otherwise stay HOLD.
- pcOut is always pc+PC_STEP when instValid=1; otherwise 0.
- Outputs are combinational from state, registers and imemAck/imemRdata. Downstream captures them at the clock edge.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- imemReq must never drop while a request is outstanding. A new address is presented only after an ack or from HOLD.
- imemAck while imemReq=0 is ignored.
- Reset asserted mid-request abandons the request. The memory is required to be reset by the same rst.

Test Plan:
- Zero-wait memory (ack same cycle as req), no freeze: 4 cycles → instValid=1 each cycle; imemAddr 0,4,8,C; pcOut 4,8,C,10.
- 2-cycle memory latency: imemAddr=0 held 2 cycles; instValid=0 in cycle 1, 1 in cycle 2 with pcOut=4; next imemAddr=4.
- Ack with freeze=1 for 3 cycles on instruction 0x1234_5678 at PC 8: HOLD entered; instOut stays 0x1234_5678, imemReq=0. When freeze drops: accepted once, next imemAddr=C, no duplicate delivery.
- branchTaken to 0x100 while a request to 0x10 is outstanding, ack 2 cycles later: DROP keeps imemAddr=0x10; instValid=0 throughout; rdata discarded; next imemAddr=0x100.
- branchTaken + freeze together while in HOLD → held instruction dropped; next imemAddr=branchAddr. Also branchTaken with ack in REQ → instValid=0, next imemAddr=branchAddr.
- rst pulled low mid-WAIT (reqAddr=0x20) → outputs zero immediately. After release: imemAddr=RESET_PC, pc sequence restarts. Also wrap test: pc=32'hFFFF_FFFC accepted → next imemAddr=0.
